player_control: RTL
===================

PLAYER_CONTROL -- requirements
Module: player_control

Interface
REQ-001 The block SHALL have parameter NUM_SONGS, default 4, meaning number of selectable songs (2..2^SONG_W).
REQ-002 The block SHALL have parameter SONG_W, default 2, meaning width of song index.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 1000, meaning silent clk cycles between consecutive songs in auto-advance (>=1).
REQ-004 The block SHALL have port clk, input, 1, meaning system clock; the block SHALL use only this one clock.
REQ-005 The block SHALL have port reset, input, 1, meaning reset; reset SHALL be synchronous and active-high.
REQ-006 The block SHALL have port play_pulse, input, 1, meaning one-cycle clean play/pause button pulse.
REQ-007 The block SHALL have port next_pulse, input, 1, meaning one-cycle next-song button pulse.
REQ-008 The block SHALL have port prev_pulse, input, 1, meaning one-cycle previous-song button pulse.
REQ-009 The block SHALL have port mode_pulse, input, 1, meaning one-cycle repeat-mode toggle button pulse.
REQ-010 The block SHALL have port song_done, input, 1, meaning one-cycle pulse from note sequencer at end of current song.
REQ-011 The block SHALL have port song_sel, output, SONG_W, meaning selected song index.
REQ-012 The block SHALL have port playing, output, 1, meaning sequencer run enable.
REQ-013 The block SHALL have port restart, output, 1, meaning one-cycle pulse commanding sequencer to restart song_sel from its first note.
REQ-014 The block SHALL have port repeat_mode, output, 1, meaning 1 = repeat current song, 0 = advance.
REQ-015 The block SHALL have port state, output, 2, meaning current FSM state code.

Function
REQ-016 All outputs SHALL be registered; every response SHALL appear on the clk edge after the triggering input cycle (latency 1).
REQ-017 FSM states SHALL be STOP=2'b00, PLAY=2'b01, PAUSE=2'b10, GAP=2'b11; playing SHALL be 1 only in PLAY.
REQ-018 Input priority within one cycle SHALL be play_pulse > next_pulse > prev_pulse > song_done; lower-priority FSM inputs that cycle SHALL be ignored; mode_pulse is independent and SHALL always act.
REQ-019 STOP: play_pulse -> PLAY with restart; next/prev -> change song_sel, stay STOP, no restart; song_done ignored.
REQ-020 PLAY: play_pulse -> PAUSE, no restart; next/prev -> change song_sel, restart, stay PLAY; song_done -> GAP, gap counter loaded with GAP_CYCLES-1.
REQ-021 PAUSE: play_pulse -> PLAY, no restart (resume); next/prev -> change song_sel, restart, stay PAUSE; song_done ignored.
REQ-022 GAP: counter decrements once per cycle; at counter 0 -> PLAY with restart, song_sel advanced by +1 if repeat_mode=0, unchanged if 1; GAP SHALL last exactly GAP_CYCLES cycles.
REQ-023 GAP: play_pulse -> STOP, counter cleared, song_sel unchanged; next/prev -> abort gap, change song_sel, PLAY with restart; song_done ignored.
REQ-024 next SHALL wrap NUM_SONGS-1 -> 0; prev SHALL wrap 0 -> NUM_SONGS-1; song_sel SHALL never exceed NUM_SONGS-1.
REQ-025 mode_pulse SHALL toggle repeat_mode in any state without affecting state, song_sel or restart; repeat_mode SHALL be sampled at the cycle GAP expires.
REQ-026 restart SHALL be high for exactly one cycle per qualifying event and 0 otherwise.

Reset
REQ-027 While reset=1 at a clk edge: state=STOP, song_sel=0, playing=0, restart=0, repeat_mode=0, gap counter=0; reset SHALL override all simultaneous inputs.
REQ-028 Reset asserted mid-PLAY or mid-GAP SHALL return to the REQ-027 values on the next edge with no restart pulse emitted.

Verification
REQ-029 After reset, play_pulse -> next cycle state=PLAY, playing=1, restart=1 for 1 cycle, song_sel=0.
REQ-030 In PLAY song_sel=3 (NUM_SONGS=4), next_pulse -> song_sel=0, restart=1; then prev_pulse -> song_sel=3, restart=1.
REQ-031 GAP_CYCLES=5, PLAY song 1, repeat_mode=0, song_done -> GAP for exactly 5 cycles, playing=0, then PLAY, song_sel=2, restart=1; repeat with repeat_mode=1 -> song_sel stays 1.
REQ-032 In PLAY, play_pulse and next_pulse same cycle -> PAUSE, song_sel unchanged, restart=0; then play_pulse -> PLAY, restart=0.
REQ-033 In GAP with counter mid-count, reset=1 with play_pulse=1 -> STOP, song_sel=0, repeat_mode=0, restart=0; song_done in STOP/PAUSE -> no state change.

Source files
------------

// File: rtl/player_control.sv
// player_control: play/pause/next/prev/repeat controller for a note sequencer.
// Tracks the selected song, run enable and the silent gap between songs.
// Every output is a flop, so each response appears one edge after its input.
module player_control #(
  parameter int NUM_SONGS  = 4,
  parameter int SONG_W     = 2,
  parameter int GAP_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_pulse,
  input  logic              next_pulse,
  input  logic              prev_pulse,
  input  logic              mode_pulse,
  input  logic              song_done,
  output logic [SONG_W-1:0] song_sel,
  output logic              playing,
  output logic              restart,
  output logic              repeat_mode,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_PAUSE = 2'b10,
    ST_GAP   = 2'b11
  } state_t;

  // Counter holds GAP_CYCLES-1 down to 0, so GAP spans exactly GAP_CYCLES cycles.
  localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  state_t              state_q, state_d;
  logic [SONG_W-1:0]   song_sel_q, song_sel_d;
  logic                playing_q, playing_d;
  logic                restart_q, restart_d;
  logic                repeat_mode_q, repeat_mode_d;
  logic [CNT_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [SONG_W-1:0]   nav_song;
  logic                nav;

  function automatic logic [SONG_W-1:0] inc_song(input logic [SONG_W-1:0] s);
    return (s == LAST_SONG) ? '0 : s + SONG_W'(1);
  endfunction

  function automatic logic [SONG_W-1:0] dec_song(input logic [SONG_W-1:0] s);
    return (s == '0) ? LAST_SONG : s - SONG_W'(1);
  endfunction

  // Next-state logic; priority play > next > prev > song_done, mode toggles independently.
  always_comb begin
    state_d       = state_q;
    song_sel_d    = song_sel_q;
    restart_d     = 1'b0;
    repeat_mode_d = repeat_mode_q ^ mode_pulse;
    gap_cnt_d     = gap_cnt_q;
    nav           = next_pulse | prev_pulse;
    nav_song      = next_pulse ? inc_song(song_sel_q) : dec_song(song_sel_q);

    case (state_q)
      ST_STOP: begin
        if (play_pulse) begin
          state_d   = ST_PLAY;
          restart_d = 1'b1;
        end else if (nav) begin
          song_sel_d = nav_song;
        end
      end
      ST_PLAY: begin
        if (play_pulse) begin
          state_d = ST_PAUSE;
        end else if (nav) begin
          song_sel_d = nav_song;
          restart_d  = 1'b1;
        end else if (song_done) begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LOAD;
        end
      end
      ST_PAUSE: begin
        if (play_pulse) begin
          state_d = ST_PLAY;
        end else if (nav) begin
          song_sel_d = nav_song;
          restart_d  = 1'b1;
        end
      end
      ST_GAP: begin
        if (play_pulse) begin
          state_d   = ST_STOP;
          gap_cnt_d = '0;
        end else if (nav) begin
          state_d    = ST_PLAY;
          song_sel_d = nav_song;
          restart_d  = 1'b1;
          gap_cnt_d  = '0;
        end else if (gap_cnt_q == '0) begin
          // Repeat mode is taken as it stands in the expiry cycle.
          state_d    = ST_PLAY;
          restart_d  = 1'b1;
          song_sel_d = repeat_mode_q ? song_sel_q : inc_song(song_sel_q);
        end else begin
          gap_cnt_d = gap_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_STOP;
      end
    endcase

    playing_d = (state_d == ST_PLAY);
  end

  // State and output registers with synchronous reset overriding all inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_STOP;
      song_sel_q    <= '0;
      playing_q     <= 1'b0;
      restart_q     <= 1'b0;
      repeat_mode_q <= 1'b0;
      gap_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      song_sel_q    <= song_sel_d;
      playing_q     <= playing_d;
      restart_q     <= restart_d;
      repeat_mode_q <= repeat_mode_d;
      gap_cnt_q     <= gap_cnt_d;
    end
  end

  assign song_sel    = song_sel_q;
  assign playing     = playing_q;
  assign restart     = restart_q;
  assign repeat_mode = repeat_mode_q;
  assign state       = state_q;

endmodule
